// File: rtl/sample_iter_pkg.sv
// Shared types, sizes and helpers for the sample iterator.
// Macro SAMPLE_ITER_PERF_EN (see sample_iterator.sv) adds a sample counter.
package sample_iter_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;
  localparam int EXT    = SIGFIG + 1;

  typedef logic [SIGFIG-1:0]                word_t;
  typedef logic signed [EXT-1:0]            ext_t;
  typedef word_t [VERTS-1:0][AXIS-1:0]      tri_t;
  typedef word_t [COLORS-1:0]               color_t;
  typedef word_t [1:0][1:0]                 box_t;   // [corner][axis]
  typedef word_t [1:0][SAMPS-1:0]           samp_t;  // [axis][lane]

  localparam word_t PIXEL = word_t'(1) << RADIX;

  typedef enum logic {WAIT, TEST} state_t;

  // One-hot subsample spacing to step size in fixed point.
  function automatic word_t step_decode(input logic [3:0] sub);
    word_t s;
    case (sub)
      4'b1000: s = PIXEL;
      4'b0100: s = PIXEL >> 1;
      4'b0010: s = PIXEL >> 2;
      4'b0001: s = PIXEL >> 3;
      default: s = PIXEL;
    endcase
    return s;
  endfunction

  // Sign-extend a coordinate into the guard-bit width.
  function automatic ext_t sx(input word_t w);
    return ext_t'($signed(w));
  endfunction

  // Zero-extend a (positive) step into the guard-bit width.
  function automatic ext_t zx(input word_t w);
    return $signed({1'b0, w});
  endfunction
endpackage

// File: rtl/sample_iterator_if.sv
// Triangle handshake from the bounding-box stage (valid / ready-hold).
interface sample_iterator_if;
  import sample_iter_pkg::*;

  tri_t   tri_R13S;
  color_t color_R13U;
  box_t   box_R13S;
  logic   validTri_R13H;
  logic   halt_RnnnnL;

  modport master (output tri_R13S, color_R13U, box_R13S, validTri_R13H,
                  input  halt_RnnnnL);
  modport slave  (input  tri_R13S, color_R13U, box_R13S, validTri_R13H,
                  output halt_RnnnnL);
endinterface

// File: rtl/sample_iterator.sv
// Walks a triangle's bounding box row-major from lower-left, emitting SAMPS
// sample positions per cycle. All R14 outputs are registered: the lane
// values are computed from the *next* walk position and captured on the
// same edge that advances it.
// Optional: SAMPLE_ITER_PERF_EN adds samp_count_R14U (saturating count of
// valid lanes emitted).
module sample_iterator
  import sample_iter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sample_iterator_if.slave     up,
  input  logic [3:0]           subSample_RnnnnU,
  output tri_t                 tri_R14S,
  output color_t               color_R14U,
  output samp_t                sample_R14S,
  output logic [SAMPS-1:0]     validSamp_R14H
`ifdef SAMPLE_ITER_PERF_EN
  ,
  output logic [31:0]          samp_count_R14U
`endif
);

  state_t state, state_nx;
  word_t  ll_x, ll_y, ur_x, ur_y, step, cur_x, cur_y;

  logic   row_end, col_end, last_cycle, halt, accept, degen, load;
  word_t  nx_x, nx_y, nx_step, nx_urx;

  word_t [SAMPS-1:0] lane_x;
  logic  [SAMPS-1:0] lane_v;

  assign up.halt_RnnnnL = halt;

  // Control: row/box termination, handshake and next walk position.
  always_comb begin
    row_end    = (sx(cur_x) + ext_t'(SAMPS) * zx(step)) > sx(ur_x);
    col_end    = (sx(cur_y) + zx(step)) > sx(ur_y);
    last_cycle = (state == TEST) && row_end && col_end;
    halt       = (state == WAIT) || last_cycle;
    accept     = up.validTri_R13H && halt;
    degen      = (sx(up.box_R13S[0][0]) > sx(up.box_R13S[1][0])) ||
                 (sx(up.box_R13S[0][1]) > sx(up.box_R13S[1][1]));
    load       = accept && !degen;

    state_nx = WAIT;
    nx_x     = cur_x;
    nx_y     = cur_y;
    nx_step  = step;
    nx_urx   = ur_x;
    if (load) begin
      state_nx = TEST;
      nx_x     = up.box_R13S[0][0];
      nx_y     = up.box_R13S[0][1];
      nx_step  = step_decode(subSample_RnnnnU);
      nx_urx   = up.box_R13S[1][0];
    end else if (state == TEST && !last_cycle) begin
      state_nx = TEST;
      if (row_end) begin
        nx_x = ll_x;
        nx_y = word_t'(sx(cur_y) + zx(step));
      end else begin
        nx_x = word_t'(sx(cur_x) + ext_t'(SAMPS) * zx(step));
      end
    end
  end

  // Lane generation from the next walk position; compares in guard width.
  always_comb begin
    ext_t acc;
    acc    = sx(nx_x);
    lane_x = '0;
    lane_v = '0;
    for (int k = 0; k < SAMPS; k++) begin
      lane_x[k] = word_t'(acc);
      lane_v[k] = acc <= sx(nx_urx);
      acc       = acc + zx(nx_step);
    end
  end

  // FSM state, latched triangle/box and registered R14 outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= WAIT;
      ll_x           <= '0;
      ll_y           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      step           <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else begin
      state <= state_nx;
      cur_x <= nx_x;
      cur_y <= nx_y;
      if (load) begin
        tri_R14S   <= up.tri_R13S;
        color_R14U <= up.color_R13U;
        ll_x       <= up.box_R13S[0][0];
        ll_y       <= up.box_R13S[0][1];
        ur_x       <= up.box_R13S[1][0];
        ur_y       <= up.box_R13S[1][1];
        step       <= nx_step;
      end
      if (state_nx == TEST) begin
        for (int k = 0; k < SAMPS; k++) begin
          sample_R14S[0][k] <= lane_x[k];
          sample_R14S[1][k] <= nx_y;
        end
        validSamp_R14H <= lane_v;
      end else begin
        validSamp_R14H <= '0;
      end
    end
  end

`ifdef SAMPLE_ITER_PERF_EN
  logic [32:0] cnt_sum;

  // Widened sum so the saturation test sees the carry.
  always_comb begin
    cnt_sum = {1'b0, samp_count_R14U} + 33'($countones(validSamp_R14H));
  end

  // Saturating count of valid lanes presented on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp_count_R14U <= '0;
    else     samp_count_R14U <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
`endif

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
Walks a triangle's bounding box and emits SAMPS sample locations per cycle, row-major from lower-left, together with the triangle and its color. It sits directly upstream of the per-sample hit test and drives that block's tri/color/sample/validSamp inputs. It accepts triangles from the bounding-box stage with a ready/hold handshake (halt_RnnnnL).

Parameters:
SIGFIG, 24, bits in color and position
RADIX, 10, fraction bits; one pixel = 1<<RADIX
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels
SAMPS, 4, samples emitted per cycle (lanes, stepped along x)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
tri_R13S  in  signed SIGFIG [VERTS][AXIS]  triangle
color_R13U  in  unsigned SIGFIG [COLORS]  triangle color
box_R13S  in  signed SIGFIG [2][2]  [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y; snapped to the step grid
validTri_R13H  in  1  triangle and box valid
subSample_RnnnnU  in  4  one-hot spacing: 1000=1.0, 0100=0.5, 0010=0.25, 0001=0.125 pixel
halt_RnnnnL  out  1  high = ready to accept a triangle; low = upstream holds
tri_R14S  out  signed SIGFIG [VERTS][AXIS]  latched triangle
color_R14U  out  unsigned SIGFIG [COLORS]  latched color
sample_R14S  out  signed SIGFIG [2][SAMPS]  sample x/y per lane
validSamp_R14H  out  1 [SAMPS]  lane valid

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- step = 1 << (RADIX - {0,1,2,3}), decoded from subSample_RnnnnU. subSample is quasi-static and is sampled only on acceptance.
- FSM states: WAIT, TEST. Reset forces WAIT. All outputs reset to 0, except halt_RnnnnL, which resets to 1.
- halt_RnnnnL = (state==WAIT) | last_cycle. The output is combinational from state and registers only.
- Acceptance: validTri_R13H & halt_RnnnnL. On acceptance, latch tri, color, box and step; set cur=(ll_x, ll_y); go to TEST. validTri while halt is low is ignored; upstream must hold it.
- Degenerate box (ll_x>ur_x or ll_y>ur_y) on acceptance: the triangle is dropped, the FSM stays in (or returns to) WAIT, and no lanes go valid.
- TEST, each cycle: lane k drives x=cur_x+k*step, y=cur_y. validSamp[k] = (x<=ur_x). Lane 0 is always valid.
- Advance: if cur_x+SAMPS*step>ur_x, the row ends. If the row ends and cur_y+step>ur_y, this is last_cycle. Otherwise on row end, cur=(ll_x, cur_y+step); if not row end, cur_x+=SAMPS*step.
- last_cycle with acceptance: the next triangle starts the next cycle with no bubble. last_cycle without acceptance: go to WAIT.
- In WAIT, validSamp=0. sample/tri/color hold their last values.
- Latency: acceptance at cycle N puts the first lanes on the R14 outputs at N+1. All R14 outputs are registered.
- Arithmetic: all x/y sums and compares are done in SIGFIG+1 signed bits so that cur+SAMPS*step cannot wrap near full scale.
- Reset mid-TEST: validSamp clears immediately (async); the first acceptance is possible on the first clock after reset deasserts.
- There is no downstream backpressure; the downstream pipeline is always ready.

Optional Feature:
Macro SAMPLE_ITER_PERF_EN.
- Defined: adds output samp_count_R14U (32b unsigned). Each cycle it adds popcount(validSamp_R14H), saturates at 2^32-1, and reset clears it.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sample_iter_pkg holds:
  - the state enum (WAIT, TEST);
  - the function step_decode(subSample) returning the SIGFIG-bit step;
  - the localparam PIXEL = 1<<RADIX.
- No sub-module is needed. Lane generation is a for-loop in one always_comb, and the FSM plus registers sit in a single always_ff.

Test Plan:
- RADIX=10, SAMPS=4, 1.0 spacing, box (0,0)-(1024,0): cycle N+1 x={0,1024,2048,3072}, y=0, valid=1100, halt high that cycle; N+2 in WAIT with valid=0000.
- Box (0,0)-(3072,1024), 1.0 spacing: two emission cycles with x={0..3072}, y=0 then y=1024, all lanes valid; halt low on the first, high on the second.
- Box (0,0)-(1024,512), 0.5 spacing: rows y=0 and y=512, each x={0,512,1024,1536} with valid=1110; 2 cycles.
- Degenerate box (2048,0)-(1024,0): halt stays 1 and validSamp stays 0000 for all following cycles.
- Back-to-back: tri B presented with validTri held during A's last cycle. B's first lanes appear the very next cycle, and its tri/color output matches B.
- rst asserted mid-row of a 4-row box: validSamp drops to 0000 asynchronously. After release halt=1, and a new box (0,0)-(0,0) yields one cycle with valid=1000 at x=0, y=0.
